// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 34-cycle multiply/divide unit holding the HI/LO registers
module mult_div_unit #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [WORD_W-1:0] port_a,
    input  logic [WORD_W-1:0] port_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [WORD_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] LAST_STEP = 6'd31;

    logic [1:0]          state;
    logic [5:0]          cnt;
    logic                is_div;
    logic                res_neg;
    logic                dvd_neg;
    logic                b_zero;
    logic [WORD_W-1:0]   orig_a;
    logic [WORD_W-1:0]   mag_a;
    logic [WORD_W-1:0]   mag_b;
    logic [2*WORD_W-1:0] acc;
    logic [WORD_W-1:0]   rem;
    logic [WORD_W-1:0]   quo;
    logic [WORD_W-1:0]   hi_q;
    logic [WORD_W-1:0]   lo_q;

    // md_op[0] clear selects the signed flavour of each op
    logic              in_signed;
    logic [WORD_W-1:0] abs_a;
    logic [WORD_W-1:0] abs_b;

    assign in_signed = ~md_op[0];
    assign abs_a     = (in_signed && port_a[WORD_W-1]) ? -port_a : port_a;
    assign abs_b     = (in_signed && port_b[WORD_W-1]) ? -port_b : port_b;

    // One shift-add step: low half of acc holds the remaining multiplier bits
    logic [WORD_W:0]     mul_sum;
    logic [2*WORD_W-1:0] acc_next;

    assign mul_sum  = {1'b0, acc[2*WORD_W-1:WORD_W]} + (acc[0] ? {1'b0, mag_a} : {(WORD_W+1){1'b0}});
    assign acc_next = {mul_sum, acc[WORD_W-1:1]};

    // One restoring-division step on the 33-bit partial remainder
    logic [WORD_W:0]   rem_shift;
    logic [WORD_W+1:0] rem_diff;
    logic              q_bit;
    logic              unused_rem_bit;

    assign rem_shift      = {rem, quo[WORD_W-1]};
    assign rem_diff       = {1'b0, rem_shift} - {2'b00, mag_b};
    assign q_bit          = ~rem_diff[WORD_W+1];
    assign unused_rem_bit = rem_diff[WORD_W];

    // Sign correction and result selection applied on the FIX cycle
    logic [2*WORD_W-1:0] prod_fix;
    logic [WORD_W-1:0]   quo_fix;
    logic [WORD_W-1:0]   rem_fix;
    logic [WORD_W-1:0]   fix_hi;
    logic [WORD_W-1:0]   fix_lo;

    assign prod_fix = res_neg ? -acc : acc;
    assign quo_fix  = res_neg ? -quo : quo;
    assign rem_fix  = dvd_neg ? -rem : rem;

    // Pick the HI/LO pair for the finished op; divide-by-zero returns the raw dividend and all ones
    always_comb begin
        fix_hi = prod_fix[2*WORD_W-1:WORD_W];
        fix_lo = prod_fix[WORD_W-1:0];
        if (is_div) begin
            if (b_zero) begin
                fix_hi = orig_a;
                fix_lo = {WORD_W{1'b1}};
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    // Control FSM and iterative datapath
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            dvd_neg <= 1'b0;
            b_zero  <= 1'b0;
            orig_a  <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            rem     <= '0;
            quo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CALC;
                        cnt     <= '0;
                        is_div  <= md_op[1];
                        res_neg <= in_signed & (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
                        dvd_neg <= in_signed & port_a[WORD_W-1];
                        b_zero  <= (port_b == '0);
                        orig_a  <= port_a;
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        acc     <= {{WORD_W{1'b0}}, abs_b};
                        rem     <= '0;
                        quo     <= abs_a;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= q_bit ? rem_diff[WORD_W-1:0] : rem_shift[WORD_W-1:0];
                        quo <= {quo[WORD_W-2:0], q_bit};
                    end else begin
                        acc <= acc_next;
                    end
                    if (cnt == LAST_STEP) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                FIX: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO: loaded from FIX results, or by MTHI/MTLO in IDLE when no op is starting
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (state == IDLE && !start) begin
            if (hi_we) begin
                hi_q <= wdat;
            end
            if (lo_we) begin
                lo_q <= wdat;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    logic        CLK    = 1'b0;
    logic        nRST   = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  md_op  = 2'b00;
    logic [31:0] port_a = '0;
    logic [31:0] port_b = '0;
    logic        hi_we  = 1'b0;
    logic        lo_we  = 1'b0;
    logic [31:0] wdat   = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          n_ops    = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    mult_div_unit dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .start  (start),
        .md_op  (md_op),
        .port_a (port_a),
        .port_b (port_b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdat   (wdat),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding op
    always @(negedge CLK) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pending op, expected done=0");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.e0), 32'd33);
            end
        end
    end

    // mode: 0 plain, 1 second start mid-CALC, 2 MTHI/MTLO mid-CALC, 3 MTHI with start
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int mode);
        int   n;
        exp_t e;
        n_ops++;
        @(negedge CLK);
        start  = 1'b1;
        md_op  = op;
        port_a = a;
        port_b = b;
        if (mode == 3) begin
            hi_we = 1'b1;
            wdat  = 32'hDEADBEEF;
        end
        @(negedge CLK);
        start  = 1'b0;
        hi_we  = 1'b0;
        md_op  = ~op;
        port_a = $urandom;
        port_b = $urandom;
        e.hi   = eh;
        e.lo   = el;
        e.e0   = cyc;
        e.name = name;
        sb.push_back(e);
        n = 0;
        while (busy && n < 100) begin
            if (n == 0 && mode == 3) check({name, "_mthi_dropped"}, hi, m_hi);
            if (n == 5 && mode == 1) begin
                start  = 1'b1;
                md_op  = 2'b01;
                port_a = 32'd7;
                port_b = 32'd9;
            end
            if (n == 6) start = 1'b0;
            if (n == 10 && mode == 2) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdat  = 32'h5A5A5A5A;
            end
            if (n == 11 && mode == 2) begin
                hi_we = 1'b0;
                lo_we = 1'b0;
                check({name, "_hi_hold_calc"}, hi, m_hi);
                check({name, "_lo_hold_calc"}, lo, m_lo);
            end
            n++;
            @(negedge CLK);
        end
        check({name, "_busy_cycles"}, 32'(n), 32'd34);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        run_op("mult_neg3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run_op("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
        run_op("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       0);
        run_op("div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu_by0",      2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1);
        run_op("div_by0",       2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 0);

        @(negedge CLK);
        hi_we = 1'b1;
        wdat  = 32'hA5A5A5A5;
        @(negedge CLK);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hA5A5A5A5);
        check("mthi_lo_kept", lo, m_lo);
        m_hi  = 32'hA5A5A5A5;
        lo_we = 1'b1;
        wdat  = 32'h0F0F0F0F;
        @(negedge CLK);
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0F0F0F0F);
        check("mtlo_hi_kept", hi, 32'hA5A5A5A5);
        m_lo  = 32'h0F0F0F0F;

        run_op("multu_2p16sq",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2);
        run_op("multu_6x7_we",  2'b01, 32'd6,        32'd7,        32'h00000000, 32'd42,       3);

        @(negedge CLK);
        start  = 1'b1;
        md_op  = 2'b00;
        port_a = 32'd3;
        port_b = 32'd5;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        check("abort_busy_before", 32'(busy), 32'h1);
        nRST = 1'b0;
        #1;
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (40) @(negedge CLK);
        check("abort_idle_busy", 32'(busy), 32'h0);
        m_hi = '0;
        m_lo = '0;

        run_op("divu_9_3",      2'b11, 32'd9,        32'd3,        32'h00000000, 32'd3,        0);

        repeat (3) @(negedge CLK);
        check("done_pulse_count", 32'(done_cnt), 32'(n_ops));
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
